bp_cce_pending_write_sched: RTL and testbench

//   Shares the CCE pending-bit write port between the microcode and the message unit.

---
 rtl/bp_cce_pending_write_sched.sv | 144 ++++++++++++++
 tb/tb_bp_cce_pending_write_sched.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bp_cce_pending_write_sched.sv
// bp_cce_pending_write_sched
//   Arbitrates the CCE pending-bit write port between the microcode and the
//   message unit. Message-unit requests win by default. A saturating starvation
//   counter forces a waiting microcode request through after starve_limit_p
//   consecutive message wins. The winner is held in a one-entry output register
//   that is drained through a valid/ready handshake.
//   Optional feature macro: BP_CCE_PEND_COALESCE_EN. When it is defined, both
//   requesters are accepted together if their address and bypass fields match,
//   and a single write is issued that carries the message-unit pending value.
module bp_cce_pending_write_sched #(
    parameter int unsigned paddr_width_p  = 40,
    parameter int unsigned starve_limit_p = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     ucode_v_i,
    input  logic [paddr_width_p-1:0] ucode_addr_i,
    input  logic                     ucode_addr_bypass_i,
    input  logic                     ucode_pending_i,
    output logic                     ucode_ready_o,

    input  logic                     msg_v_i,
    input  logic [paddr_width_p-1:0] msg_addr_i,
    input  logic                     msg_addr_bypass_i,
    input  logic                     msg_pending_i,
    output logic                     msg_ready_o,

    output logic                     pending_w_v_o,
    output logic [paddr_width_p-1:0] pending_w_addr_o,
    output logic                     pending_w_addr_bypass_o,
    output logic                     pending_o,
    input  logic                     pending_w_ready_i,

    output logic                     ucode_starved_o
);

    // A limit of 0 still needs a 1-bit counter; it simply never leaves 0.
    localparam int unsigned cnt_width_lp =
        (starve_limit_p == 0) ? 1 : $clog2(starve_limit_p + 1);
    localparam logic [cnt_width_lp-1:0] starve_limit_lp = cnt_width_lp'(starve_limit_p);

    typedef enum logic {
        e_empty = 1'b0,
        e_full  = 1'b1
    } state_e;

    state_e                   state_r, state_n;
    logic [cnt_width_lp-1:0]  cnt_r, cnt_n;
    logic [paddr_width_p-1:0] addr_r;
    logic                     bypass_r;
    logic                     pending_r;

    logic                     space;
    logic                     starve;
    logic                     coalesce;
    logic                     grant_msg;
    logic                     grant_uc;
    logic                     load;
    logic [paddr_width_p-1:0] load_addr;
    logic                     load_bypass;
    logic                     load_pending;

    // Arbitration: grants, coalescing and selection of the fields to capture
    always_comb begin
        space        = (state_r == e_empty) | pending_w_ready_i;
        starve       = (cnt_r == starve_limit_lp);
        coalesce     = 1'b0;
`ifdef BP_CCE_PEND_COALESCE_EN
        coalesce     = ucode_v_i & msg_v_i & space
                     & (ucode_addr_i == msg_addr_i)
                     & (ucode_addr_bypass_i == msg_addr_bypass_i);
`endif
        grant_msg    = (msg_v_i & space & ~(starve & ucode_v_i)) | coalesce;
        grant_uc     = (ucode_v_i & space & (~msg_v_i | starve)) | coalesce;
        load         = grant_msg | grant_uc;
        load_addr    = ucode_addr_i;
        load_bypass  = ucode_addr_bypass_i;
        load_pending = ucode_pending_i;
        // A coalesced write carries the message-unit fields (addresses match).
        if (grant_msg) begin
            load_addr    = msg_addr_i;
            load_bypass  = msg_addr_bypass_i;
            load_pending = msg_pending_i;
        end
    end

    // Starvation counter next value: clear when ucode is served or idle, saturate at the limit
    always_comb begin
        cnt_n = cnt_r;
        if (grant_uc | ~ucode_v_i) begin
            cnt_n = '0;
        end else if (grant_msg & (cnt_r < starve_limit_lp)) begin
            cnt_n = cnt_r + cnt_width_lp'(1);
        end
    end

    // Output-register occupancy next state
    always_comb begin
        state_n = state_r;
        case (state_r)
            e_empty: begin
                if (load) state_n = e_full;
            end
            e_full: begin
                if (load)                   state_n = e_full;
                else if (pending_w_ready_i) state_n = e_empty;
            end
        endcase
    end

    // State and starvation counter registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_empty;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    // Held write fields; reset discards any held entry
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_r    <= '0;
            bypass_r  <= 1'b0;
            pending_r <= 1'b0;
        end else if (load) begin
            addr_r    <= load_addr;
            bypass_r  <= load_bypass;
            pending_r <= load_pending;
        end
    end

    assign ucode_ready_o           = grant_uc;
    assign msg_ready_o             = grant_msg;
    assign pending_w_v_o           = (state_r == e_full);
    assign pending_w_addr_o        = addr_r;
    assign pending_w_addr_bypass_o = bypass_r;
    assign pending_o               = pending_r;
    assign ucode_starved_o         = starve;

endmodule

// File: tb/tb_bp_cce_pending_write_sched.sv
// Testbench for bp_cce_pending_write_sched: directed stimulus, expected writes
// queued at grant time and checked by independent output monitors.
module tb_bp_cce_pending_write_sched;

    typedef struct packed {
        logic [39:0] addr;
        logic        bypass;
        logic        pend;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_i;

    logic        ucode_v, ucode_bypass, ucode_pend;
    logic [39:0] ucode_addr;
    logic        msg_v, msg_bypass, msg_pend;
    logic [39:0] msg_addr;
    logic        rdy;
    logic        ucode_ready, msg_ready, w_v, w_bypass, w_pend, starved;
    logic [39:0] w_addr;

    logic        ucode_v0, ucode_bypass0, ucode_pend0;
    logic [39:0] ucode_addr0;
    logic        msg_v0, msg_bypass0, msg_pend0;
    logic [39:0] msg_addr0;
    logic        ucode_ready0, msg_ready0, w_v0, w_bypass0, w_pend0, starved0;
    logic [39:0] w_addr0;

    wr_t q[$];
    wr_t q0[$];
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    bp_cce_pending_write_sched #(.paddr_width_p(40), .starve_limit_p(4)) u_dut (
        .clk_i(clk), .reset_i(reset_i),
        .ucode_v_i(ucode_v), .ucode_addr_i(ucode_addr), .ucode_addr_bypass_i(ucode_bypass),
        .ucode_pending_i(ucode_pend), .ucode_ready_o(ucode_ready),
        .msg_v_i(msg_v), .msg_addr_i(msg_addr), .msg_addr_bypass_i(msg_bypass),
        .msg_pending_i(msg_pend), .msg_ready_o(msg_ready),
        .pending_w_v_o(w_v), .pending_w_addr_o(w_addr), .pending_w_addr_bypass_o(w_bypass),
        .pending_o(w_pend), .pending_w_ready_i(rdy), .ucode_starved_o(starved)
    );

    bp_cce_pending_write_sched #(.paddr_width_p(40), .starve_limit_p(0)) u_dut0 (
        .clk_i(clk), .reset_i(reset_i),
        .ucode_v_i(ucode_v0), .ucode_addr_i(ucode_addr0), .ucode_addr_bypass_i(ucode_bypass0),
        .ucode_pending_i(ucode_pend0), .ucode_ready_o(ucode_ready0),
        .msg_v_i(msg_v0), .msg_addr_i(msg_addr0), .msg_addr_bypass_i(msg_bypass0),
        .msg_pending_i(msg_pend0), .msg_ready_o(msg_ready0),
        .pending_w_v_o(w_v0), .pending_w_addr_o(w_addr0), .pending_w_addr_bypass_o(w_bypass0),
        .pending_o(w_pend0), .pending_w_ready_i(1'b1), .ucode_starved_o(starved0)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the limit-4 instance: every presented write must match the queue head
    always @(negedge clk) begin
        if (w_v === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h, expected no write", w_addr);
            end else begin
                chk("wr_addr", 64'(w_addr), 64'(q[0].addr));
                chk("wr_bypass", 64'(w_bypass), 64'(q[0].bypass));
                chk("wr_pending", 64'(w_pend), 64'(q[0].pend));
                if (rdy) void'(q.pop_front());
            end
        end
    end

    // Monitor for the limit-0 instance (always ready)
    always @(negedge clk) begin
        if (w_v0 === 1'b1) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write0: got addr %0h, expected no write", w_addr0);
            end else begin
                chk("wr0_addr", 64'(w_addr0), 64'(q0[0].addr));
                chk("wr0_pending", 64'(w_pend0), 64'(q0[0].pend));
                void'(q0.pop_front());
            end
        end
    end

    // One cycle of stimulus on the limit-4 instance with expected handshake results
    task automatic step(input logic uv, input logic [39:0] ua, input logic ub, input logic up,
                        input logic mv, input logic [39:0] ma, input logic mb, input logic mp,
                        input logic r, input logic exp_ur, input logic exp_mr,
                        input logic exp_st, input string tag);
        @(posedge clk);
        #1;
        ucode_v = uv; ucode_addr = ua; ucode_bypass = ub; ucode_pend = up;
        msg_v = mv; msg_addr = ma; msg_bypass = mb; msg_pend = mp;
        rdy = r;
        @(negedge clk);
        chk({tag, " ucode_ready"}, 64'(ucode_ready), 64'(exp_ur));
        chk({tag, " msg_ready"}, 64'(msg_ready), 64'(exp_mr));
        chk({tag, " starved"}, 64'(starved), 64'(exp_st));
        if (exp_mr)      q.push_back(wr_t'{addr: ma, bypass: mb, pend: mp});
        else if (exp_ur) q.push_back(wr_t'{addr: ua, bypass: ub, pend: up});
    endtask

    task automatic idle(input string tag);
        step(1'b0, 40'h0, 1'b0, 1'b0, 1'b0, 40'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_i = 1'b1;
        ucode_v = 0; ucode_addr = '0; ucode_bypass = 0; ucode_pend = 0;
        msg_v = 0; msg_addr = '0; msg_bypass = 0; msg_pend = 0; rdy = 0;
        ucode_v0 = 0; ucode_addr0 = '0; ucode_bypass0 = 0; ucode_pend0 = 0;
        msg_v0 = 0; msg_addr0 = '0; msg_bypass0 = 0; msg_pend0 = 0;
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        chk("reset w_v", 64'(w_v), 64'(0));
        chk("reset w_addr", 64'(w_addr), 64'(0));
        chk("reset pending", 64'(w_pend), 64'(0));
        chk("reset starved", 64'(starved), 64'(0));
        chk("reset ready", 64'({ucode_ready, msg_ready}), 64'(0));

        // Single message-unit write, one cycle latency to the output
        step(0, 40'h0, 0, 0, 1, 40'h100, 0, 1, 1, 0, 1, 0, "t1");
        idle("t1 idle");

        // Continuous contention: four msg wins, then a forced ucode win, twice
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4)
                step(1, 40'h200, 1, 0, 1, 40'h300, 0, 1, 1, 1, 0, 1, "t2 uc");
            else
                step(1, 40'h200, 1, 0, 1, 40'h300, 0, 1, 1, 0, 1, 0, "t2 msg");
        end

        // Stall: a held entry with ready low blocks both requesters
        step(1, 40'h210, 0, 1, 1, 40'h310, 1, 0, 1, 0, 1, 0, "t3 load");
        for (int i = 0; i < 3; i++)
            step(1, 40'h210, 0, 1, 1, 40'h320, 1, 1, 0, 0, 0, 0, "t3 stall");
        step(1, 40'h210, 0, 1, 1, 40'h330, 0, 1, 1, 0, 1, 0, "t3 resume");
        idle("t3 idle");

        // Reach the starvation limit, hold the entry, then reset mid-operation
        for (int i = 0; i < 4; i++)
            step(1, 40'h400, 0, 1, 1, 40'h410 + 40'(i), 0, 1, 1, 0, 1, 0, "t4 fill");
        step(1, 40'h400, 0, 1, 1, 40'h420, 0, 1, 0, 0, 0, 1, "t4 held");
        @(posedge clk);
        #1;
        reset_i = 1'b1; ucode_v = 0; msg_v = 0; rdy = 0;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        q.delete();
        @(negedge clk);
        chk("t4 w_v after reset", 64'(w_v), 64'(0));
        chk("t4 starved after reset", 64'(starved), 64'(0));
        idle("t4 idle0");
        idle("t4 idle1");

        // Same-address requests
`ifdef BP_CCE_PEND_COALESCE_EN
        step(1, 40'h240, 0, 0, 1, 40'h240, 0, 1, 1, 1, 1, 0, "t5 coalesce");
`else
        step(1, 40'h240, 0, 0, 1, 40'h240, 0, 1, 1, 0, 1, 0, "t5 msg");
        step(1, 40'h240, 0, 0, 0, 40'h240, 0, 1, 1, 1, 0, 0, "t5 uc");
`endif
        idle("t5 idle");

        // Limit 0: ucode always wins when valid
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            ucode_v0 = 1; ucode_addr0 = 40'h500 + 40'(i); ucode_pend0 = i[0];
            msg_v0 = 1; msg_addr0 = 40'h600; msg_pend0 = 1;
            @(negedge clk);
            chk("t6 ucode_ready", 64'(ucode_ready0), 64'(1));
            chk("t6 msg_ready", 64'(msg_ready0), 64'(0));
            chk("t6 starved", 64'(starved0), 64'(1));
            q0.push_back(wr_t'{addr: ucode_addr0, bypass: 1'b0, pend: ucode_pend0});
        end
        @(posedge clk);
        #1;
        ucode_v0 = 0; msg_v0 = 0;
        repeat (3) @(negedge clk);

        chk("queue drained", 64'(q.size()), 64'(0));
        chk("queue0 drained", 64'(q0.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
